// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB completer between N_MASTERS APB requesters.
// Latency: request seen in IDLE at t -> SETUP t+1 -> ACCESS t+2 (one extra wait state over a direct link).
// Backpressure: losing masters and the granted master are held with pready low until downstream completes.
module apb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDXW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    localparam int STRBW = DATA_WIDTH / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            s_apb_psel,
    input  logic [N_MASTERS-1:0]            s_apb_penable,
    input  logic [N_MASTERS-1:0]            s_apb_pwrite,
    input  logic [3*N_MASTERS-1:0]          s_apb_pprot,
    input  logic [ADDR_WIDTH*N_MASTERS-1:0] s_apb_paddr,
    input  logic [DATA_WIDTH*N_MASTERS-1:0] s_apb_pwdata,
    input  logic [STRBW*N_MASTERS-1:0]      s_apb_pstrb,
    output logic [N_MASTERS-1:0]            s_apb_pready,
    output logic [DATA_WIDTH-1:0]           s_apb_prdata,
    output logic                            s_apb_pslverr,
    output logic                            m_apb_psel,
    output logic                            m_apb_penable,
    output logic                            m_apb_pwrite,
    output logic [2:0]                      m_apb_pprot,
    output logic [ADDR_WIDTH-1:0]           m_apb_paddr,
    output logic [DATA_WIDTH-1:0]           m_apb_pwdata,
    output logic [STRBW-1:0]                m_apb_pstrb,
    input  logic                            m_apb_pready,
    input  logic [DATA_WIDTH-1:0]           m_apb_prdata,
    input  logic                            m_apb_pslverr,
    output logic [IDXW-1:0]                 grant_idx,
    output logic                            busy
);

    localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    typedef struct packed {
        logic                  pwrite;
        logic [2:0]            pprot;
        logic [ADDR_WIDTH-1:0] paddr;
        logic [DATA_WIDTH-1:0] pwdata;
        logic [STRBW-1:0]      pstrb;
    } req_t;

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic            psel_q, psel_d;
    logic            pen_q, pen_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [CNTW-1:0] wdog_q, wdog_d;

    logic            found;
    logic [IDXW-1:0] pick;
    logic            timeout_hit;
    logic            done;
    int              idx;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(last_q) + k) % N_MASTERS;
            if (!found && s_apb_psel[IDXW'(idx)]) begin
                found = 1'b1;
                pick  = IDXW'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ACCESS) && !m_apb_pready
                         && (wdog_q == CNTW'(TIMEOUT_CYCLES - 1));
    assign done = (state_q == ACCESS) && (m_apb_pready || timeout_hit);

    // A master that dropped psel mid-transfer gets no pready; the response is discarded.
    always_comb begin
        s_apb_pready = '0;
        if (done && s_apb_psel[gidx_q]) begin
            s_apb_pready[gidx_q] = 1'b1;
        end
        s_apb_prdata  = ((state_q == ACCESS) && !timeout_hit) ? m_apb_prdata : '0;
        s_apb_pslverr = timeout_hit || ((state_q == ACCESS) && m_apb_pready && m_apb_pslverr);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        psel_d  = psel_q;
        pen_d   = pen_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        wdog_d  = wdog_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_d.pwrite = s_apb_pwrite[pick];
                    req_d.pprot  = s_apb_pprot[int'(pick)*3 +: 3];
                    req_d.paddr  = s_apb_paddr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    req_d.pwdata = s_apb_pwdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    req_d.pstrb  = s_apb_pstrb[int'(pick)*STRBW +: STRBW];
                    psel_d       = 1'b1;
                    last_d       = pick;
                    gidx_d       = pick;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                wdog_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            last_q  <= IDXW'(N_MASTERS - 1);
            gidx_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            psel_q  <= psel_d;
            pen_q   <= pen_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            wdog_q  <= wdog_d;
        end
    end

    assign m_apb_psel    = psel_q;
    assign m_apb_penable = pen_q;
    assign m_apb_pwrite  = req_q.pwrite;
    assign m_apb_pprot   = req_q.pprot;
    assign m_apb_paddr   = req_q.paddr;
    assign m_apb_pwdata  = req_q.pwdata;
    assign m_apb_pstrb   = req_q.pstrb;
    assign grant_idx     = gidx_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: two masters, watchdog of 8, behavioural 32x64 register block downstream.
module tb_apb_rr_arbiter;

    localparam int N  = 2;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int SW = 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [3*N-1:0]  s_pprot;
    logic [AW*N-1:0] s_paddr;
    logic [DW*N-1:0] s_pwdata;
    logic [SW*N-1:0] s_pstrb;
    logic [N-1:0]    s_pready;
    logic [DW-1:0]   s_prdata;
    logic            s_pslverr;
    logic            m_psel, m_penable, m_pwrite;
    logic [2:0]      m_pprot;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata;
    logic [SW-1:0]   m_pstrb;
    logic            slv_pready;
    logic [DW-1:0]   m_prdata;
    logic            m_pslverr;
    logic [0:0]      grant_idx;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_rr_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_apb_psel(s_psel), .s_apb_penable(s_penable), .s_apb_pwrite(s_pwrite),
        .s_apb_pprot(s_pprot), .s_apb_paddr(s_paddr), .s_apb_pwdata(s_pwdata),
        .s_apb_pstrb(s_pstrb), .s_apb_pready(s_pready), .s_apb_prdata(s_prdata),
        .s_apb_pslverr(s_pslverr),
        .m_apb_psel(m_psel), .m_apb_penable(m_penable), .m_apb_pwrite(m_pwrite),
        .m_apb_pprot(m_pprot), .m_apb_paddr(m_paddr), .m_apb_pwdata(m_pwdata),
        .m_apb_pstrb(m_pstrb), .m_apb_pready(slv_pready), .m_apb_prdata(m_prdata),
        .m_apb_pslverr(m_pslverr), .grant_idx(grant_idx), .busy(busy)
    );

    // Behavioural register block: configurable wait states, error flag, or never ready.
    logic [DW-1:0] mem [32];
    int  wcnt;
    int  slv_waits = 0;
    bit  slv_err   = 1'b0;
    bit  slv_hang  = 1'b0;

    assign slv_pready = m_psel && m_penable && !slv_hang && (wcnt >= slv_waits);
    assign m_prdata   = mem[m_paddr[7:3]];
    assign m_pslverr  = slv_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= 0;
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else begin
            if (m_psel && m_penable && !slv_pready) wcnt <= wcnt + 1;
            else                                    wcnt <= 0;
            if (slv_pready && m_pwrite) begin
                for (int b = 0; b < SW; b++)
                    if (m_pstrb[b]) mem[m_paddr[7:3]][b*8 +: 8] <= m_pwdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Every downstream SETUP cycle is logged for grant-order and field checks.
    typedef struct {
        int            gidx;
        logic [7:0]    addr;
        logic          wr;
        logic [63:0]   wd;
        logic [7:0]    strb;
    } glog_t;
    glog_t glog[$];

    always @(negedge clk) begin
        glog_t e;
        if (rst) begin
            if (m_psel && !m_penable) begin
                e.gidx = int'(grant_idx);
                e.addr = m_paddr;
                e.wr   = m_pwrite;
                e.wd   = m_pwdata;
                e.strb = m_pstrb;
                glog.push_back(e);
            end
            chk("pready_onehot", 64'($countones(s_pready) <= 1), 64'd1);
            if (s_pready != '0) chk("pready_is_granted", 64'(s_pready[grant_idx]), 64'd1);
            if (m_psel && m_penable && slv_pready && s_psel[grant_idx])
                chk("pready_same_cycle", 64'(s_pready[grant_idx]), 64'd1);
        end
    end

    task automatic xfer(input int m, input bit wr, input logic [7:0] addr, input logic [63:0] wd,
                        input logic [7:0] strb, output logic [63:0] rd, output logic err, output int lat);
        bit got;
        got = 1'b0;
        rd  = '0;
        err = 1'b0;
        lat = 0;
        s_psel[m]             = 1'b1;
        s_penable[m]          = 1'b0;
        s_pwrite[m]           = wr;
        s_pprot[m*3 +: 3]     = 3'b010;
        s_paddr[m*AW +: AW]   = addr;
        s_pwdata[m*DW +: DW]  = wd;
        s_pstrb[m*SW +: SW]   = strb;
        @(posedge clk);
        #1 s_penable[m] = 1'b1;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (s_pready[m]) begin
                got = 1'b1;
                rd  = s_prdata;
                err = s_pslverr;
            end
        end
        chk($sformatf("xfer_done_m%0d", m), 64'(got), 64'd1);
        @(posedge clk);
        #1;
        s_psel[m]    = 1'b0;
        s_penable[m] = 1'b0;
    endtask

    typedef struct {
        int          m;
        bit          wr;
        logic [7:0]  addr;
        logic [63:0] wd;
        logic [7:0]  strb;
        int          waits;
        bit          serr;
        bit          hang;
        logic [63:0] exp_rd;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd, rd0, rd1;
        logic        err, err0, err1;
        int          lat, lat0, lat1;

        vt[0] = '{0, 1'b1, 8'h18, 64'h0123456789ABCDEF, 8'hFF, 0, 1'b0, 1'b0, 64'h0, 1'b0, 2};
        vt[1] = '{0, 1'b0, 8'h18, 64'h0,                8'h00, 0, 1'b0, 1'b0, 64'h0123456789ABCDEF, 1'b0, 2};
        vt[2] = '{1, 1'b1, 8'h20, 64'hDEADBEEFCAFEF00D, 8'h0F, 1, 1'b0, 1'b0, 64'h0, 1'b0, 3};
        vt[3] = '{1, 1'b0, 8'h20, 64'h0,                8'h00, 3, 1'b0, 1'b0, 64'h00000000CAFEF00D, 1'b0, 5};
        vt[4] = '{0, 1'b0, 8'h20, 64'h0,                8'h00, 0, 1'b1, 1'b0, 64'h00000000CAFEF00D, 1'b1, 2};
        vt[5] = '{1, 1'b1, 8'hF8, 64'hFFFFFFFFFFFFFFFF, 8'h81, 2, 1'b0, 1'b0, 64'h0, 1'b0, 4};
        vt[6] = '{0, 1'b0, 8'hF8, 64'h0,                8'h00, 0, 1'b0, 1'b0, 64'hFF000000000000FF, 1'b0, 2};
        vt[7] = '{1, 1'b0, 8'h18, 64'h0,                8'h00, 0, 1'b0, 1'b1, 64'h0, 1'b1, 9};
        vt[8] = '{0, 1'b0, 8'h18, 64'h0,                8'h00, 0, 1'b0, 1'b0, 64'h0123456789ABCDEF, 1'b0, 2};

        rst = 1'b0;
        s_psel = '0; s_penable = '0; s_pwrite = '0; s_pprot = '0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0;

        repeat (2) @(negedge clk);
        chk("rst_m_psel",    64'(m_psel), 64'd0);
        chk("rst_m_penable", 64'(m_penable), 64'd0);
        chk("rst_m_pwrite",  64'(m_pwrite), 64'd0);
        chk("rst_m_paddr",   64'(m_paddr), 64'd0);
        chk("rst_m_pwdata",  m_pwdata, 64'd0);
        chk("rst_m_pstrb",   64'(m_pstrb), 64'd0);
        chk("rst_m_pprot",   64'(m_pprot), 64'd0);
        chk("rst_s_pready",  64'(s_pready), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);

        // Both masters request at reset exit: master 0 four reads, master 1 four writes; grants alternate.
        rst = 1'b1;
        glog.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 1'b0, 8'h00, 64'h0, 8'h00, rd0, err0, lat0);
                    chk("fair_m0_rd", rd0, 64'h0);
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(1, 1'b1, 8'(8'h40 + 8*i), 64'h1111 * 64'(i + 1), 8'hFF, rd1, err1, lat1);
                    if (i == 0) chk("fair_m1_first_lat", 64'(lat1), 64'd5);
                end
            end
        join
        chk("fair_grant_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size() && i < 8; i++)
            chk($sformatf("fair_grant_%0d", i), 64'(glog[i].gidx), 64'(i % 2));
        @(negedge clk);

        for (int r = 0; r < 9; r++) begin
            slv_waits = vt[r].waits;
            slv_err   = vt[r].serr;
            slv_hang  = vt[r].hang;
            glog.delete();
            xfer(vt[r].m, vt[r].wr, vt[r].addr, vt[r].wd, vt[r].strb, rd, err, lat);
            chk($sformatf("v%0d_lat", r), 64'(lat), 64'(vt[r].exp_lat));
            chk($sformatf("v%0d_err", r), 64'(err), 64'(vt[r].exp_err));
            if (!vt[r].wr) chk($sformatf("v%0d_rdata", r), rd, vt[r].exp_rd);
            chk($sformatf("v%0d_setups", r), 64'(glog.size()), 64'd1);
            if (glog.size() > 0) begin
                chk($sformatf("v%0d_gidx", r), 64'(glog[0].gidx), 64'(vt[r].m));
                chk($sformatf("v%0d_addr", r), 64'(glog[0].addr), 64'(vt[r].addr));
                chk($sformatf("v%0d_wr", r), 64'(glog[0].wr), 64'(vt[r].wr));
                if (vt[r].wr) begin
                    chk($sformatf("v%0d_wdata", r), glog[0].wd, vt[r].wd);
                    chk($sformatf("v%0d_strb", r), 64'(glog[0].strb), 64'(vt[r].strb));
                end
            end
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", r), 64'(busy), 64'd0);
            slv_hang = 1'b0;
            slv_err  = 1'b0;
        end

        // Reset during ACCESS by master 0: everything drops at once, no response.
        slv_waits = 0;
        slv_hang  = 1'b1;
        @(posedge clk);
        #1;
        s_psel[0] = 1'b1; s_pwrite[0] = 1'b0; s_paddr[0 +: AW] = 8'h30;
        @(posedge clk);
        #1 s_penable[0] = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_in_access", 64'({busy, m_penable}), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("abort_m_psel",    64'(m_psel), 64'd0);
        chk("abort_m_penable", 64'(m_penable), 64'd0);
        chk("abort_m_paddr",   64'(m_paddr), 64'd0);
        chk("abort_s_pready",  64'(s_pready), 64'd0);
        chk("abort_busy",      64'(busy), 64'd0);
        s_psel = '0; s_penable = '0;
        slv_hang = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        glog.delete();
        fork
            xfer(0, 1'b0, 8'h00, 64'h0, 8'h00, rd0, err0, lat0);
            xfer(1, 1'b0, 8'h40, 64'h0, 8'h00, rd1, err1, lat1);
        join
        chk("post_rst_grants", 64'(glog.size()), 64'd2);
        if (glog.size() == 2) begin
            chk("post_rst_first",  64'(glog[0].gidx), 64'd0);
            chk("post_rst_second", 64'(glog[1].gidx), 64'd1);
        end
        chk("post_rst_m1_rd", rd1, 64'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
